// File: rtl/y86_instr_encoder.sv
// ---------------------------------------------------------------------------
// y86_instr_encoder
//
// Purpose: takes one Y86-64 instruction at a time (field form) and writes its
// byte encoding into instruction memory, one byte per clock, starting at the
// current write pointer. The pointer then advances by the instruction length.
// Illegal opcodes and encodings that would run past MEM_TOP are rejected
// without writing anything.
//
// Configuration macro: ENC_HALT_LOCK_EN
//   defined   -> after a halt byte is written the encoder refuses further
//                instructions until rst or load_ptr.
//   undefined -> halt is an ordinary 1-byte instruction.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load_ptr          load write pointer from start_addr (honoured in IDLE only)
//   start_addr[63:0]  new write pointer value
//   in_valid/in_ready instruction handshake (ready only while idle)
//   iCode, iFun, rA, rB [3:0], valC[63:0]  instruction fields
//   wr_en, wr_addr[63:0], wr_data[7:0]     byte write to instruction memory
//   wr_ptr[63:0]      current write pointer
//   inv_err           one-cycle pulse: invalid iCode/iFun
//   ovf_err           one-cycle pulse: instruction would pass MEM_TOP
// ---------------------------------------------------------------------------
module y86_instr_encoder #(
  parameter logic [63:0] MEM_TOP = 64'd511
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_ptr,
  input  logic [63:0] start_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  iCode,
  input  logic [3:0]  iFun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [63:0] wr_ptr,
  output logic        inv_err,
  output logic        ovf_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]  icode_q, icode_d;
  logic [3:0]  ifun_q, ifun_d;
  logic [3:0]  ra_q, ra_d;
  logic [3:0]  rb_q, rb_d;
  logic [63:0] valc_q, valc_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic        inv_q, inv_d;
  logic        ovf_q, ovf_d;
  logic        lock_q;

  // Encoded length of an instruction; 0 marks an illegal iCode/iFun pair.
  function automatic logic [3:0] enc_len(input logic [3:0] code, input logic [3:0] fun);
    logic [3:0] len;
    case (code)
      4'h0, 4'h1, 4'h9:       len = (fun == 4'h0) ? 4'd1  : 4'd0;
      4'h2:                   len = (fun < 4'd7)  ? 4'd2  : 4'd0;
      4'h3, 4'h4, 4'h5:       len = (fun == 4'h0) ? 4'd10 : 4'd0;
      4'h6:                   len = (fun < 4'd4)  ? 4'd2  : 4'd0;
      4'h7:                   len = (fun < 4'd7)  ? 4'd9  : 4'd0;
      4'h8:                   len = (fun == 4'h0) ? 4'd9  : 4'd0;
      4'hA, 4'hB:             len = (fun == 4'h0) ? 4'd2  : 4'd0;
      default:                len = 4'd0;
    endcase
    return len;
  endfunction

  logic [3:0]  in_len;
  logic        in_ok;
  logic [64:0] end_addr;
  logic        in_ovf;
  logic        accept;
  logic        last_byte;
  logic        is_jump_q;
  logic [2:0]  vidx;
  logic [5:0]  vbase;
  logic [7:0]  byte_sel;

  assign in_len   = enc_len(iCode, iFun);
  assign in_ok    = (in_len != 4'd0);
  // 65-bit sum so a pointer near 2^64 that would wrap is caught as overflow.
  assign end_addr = {1'b0, wr_ptr_q} + {61'd0, in_len} - 65'd1;
  assign in_ovf   = end_addr[64] || (end_addr[63:0] > MEM_TOP);

  // in_ready already excludes load_ptr, so a simultaneous load wins.
  assign in_ready = !rst && (state_q == IDLE) && !load_ptr && !lock_q;
  assign accept   = in_valid && in_ready;

  assign last_byte = (idx_q == (len_q - 4'd1));
  // jXX/call carry no register byte, so valC starts one byte earlier.
  assign is_jump_q = (icode_q == 4'h7) || (icode_q == 4'h8);

  always_comb begin
    // valC goes out MSB-first: byte index -> valC byte number counted from LSB.
    vidx     = is_jump_q ? 3'(4'd8 - idx_q) : 3'(4'd9 - idx_q);
    vbase    = {vidx, 3'b000};
    byte_sel = valc_q[vbase +: 8];
    if (idx_q == 4'd0) begin
      byte_sel = {icode_q, ifun_q};
    end else if (!is_jump_q && (idx_q == 4'd1)) begin
      byte_sel = {ra_q, rb_q};
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    icode_d  = icode_q;
    ifun_d   = ifun_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    valc_d   = valc_q;
    len_d    = len_q;
    idx_d    = idx_q;
    inv_d    = 1'b0;
    ovf_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_ptr) begin
          wr_ptr_d = start_addr;
        end else if (accept) begin
          if (!in_ok) begin
            inv_d = 1'b1;
          end else if (in_ovf) begin
            ovf_d = 1'b1;
          end else begin
            state_d = EMIT;
            icode_d = iCode;
            ifun_d  = iFun;
            ra_d    = rA;
            rb_d    = rB;
            valc_d  = valC;
            len_d   = in_len;
            idx_d   = 4'd0;
          end
        end
      end
      EMIT: begin
        idx_d = idx_q + 4'd1;
        if (last_byte) begin
          state_d  = IDLE;
          wr_ptr_d = wr_ptr_q + {60'd0, len_q};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= 64'd0;
      icode_q  <= 4'd0;
      ifun_q   <= 4'd0;
      ra_q     <= 4'd0;
      rb_q     <= 4'd0;
      valc_q   <= 64'd0;
      len_q    <= 4'd0;
      idx_q    <= 4'd0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      icode_q  <= icode_d;
      ifun_q   <= ifun_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      valc_q   <= valc_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      inv_q    <= inv_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef ENC_HALT_LOCK_EN
  logic lock_d;

  always_comb begin
    lock_d = lock_q;
    if ((state_q == IDLE) && load_ptr) begin
      lock_d = 1'b0;
    end else if ((state_q == EMIT) && last_byte && (icode_q == 4'h0)) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign lock_q = 1'b0;
`endif

  // Write port is driven straight from state so reset silences it at once.
  assign wr_en   = (state_q == EMIT);
  assign wr_addr = wr_en ? (wr_ptr_q + {60'd0, idx_q}) : 64'd0;
  assign wr_data = wr_en ? byte_sel : 8'h00;
  assign wr_ptr  = wr_ptr_q;
  assign inv_err = inv_q;
  assign ovf_err = ovf_q;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_y86_instr_encoder
//
// Directed bench for y86_instr_encoder. A byte-stream model builds the
// expected memory writes of each instruction from the encoding rules and
// queues them; a negedge monitor checks every DUT write against that queue.
// Pointer values and selected bytes are also pinned with literal values.
// ---------------------------------------------------------------------------
module tb_y86_instr_encoder;

  localparam logic [63:0] MEM_TOP = 64'd511;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_ptr = 1'b0;
  logic [63:0] start_addr = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  iCode = 4'd0;
  logic [3:0]  iFun = 4'd0;
  logic [3:0]  rA = 4'd0;
  logic [3:0]  rB = 4'd0;
  logic [63:0] valC = 64'd0;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [7:0]  wr_data;
  logic [63:0] wr_ptr;
  logic        inv_err;
  logic        ovf_err;

  always #5 clk = ~clk;

  y86_instr_encoder #(.MEM_TOP(MEM_TOP)) dut (
    .clk(clk), .rst(rst), .load_ptr(load_ptr), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .iCode(iCode), .iFun(iFun), .rA(rA), .rB(rB), .valC(valC),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ptr(wr_ptr),
    .inv_err(inv_err), .ovf_err(ovf_err)
  );

  typedef struct packed {
    logic [63:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] log_a[$];
  logic [7:0]  log_d[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          inv_cnt = 0;
  int          ovf_cnt = 0;
  int          exp_inv = 0;
  int          exp_ovf = 0;
  logic [63:0] model_ptr = 64'd0;
  logic [7:0]  mb [10];
  int          mb_n;
  int          base;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Byte list of one instruction from the encoding rules; mb_n = 0 if illegal.
  task automatic build(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc);
    int len;
    int k;
    case (ic)
      4'h0, 4'h1, 4'h9: len = (ifn == 4'd0) ? 1 : 0;
      4'h2:             len = (ifn < 4'd7) ? 2 : 0;
      4'h3, 4'h4, 4'h5: len = (ifn == 4'd0) ? 10 : 0;
      4'h6:             len = (ifn < 4'd4) ? 2 : 0;
      4'h7:             len = (ifn < 4'd7) ? 9 : 0;
      4'h8:             len = (ifn == 4'd0) ? 9 : 0;
      4'hA, 4'hB:       len = (ifn == 4'd0) ? 2 : 0;
      default:          len = 0;
    endcase
    mb_n = len;
    for (int i = 0; i < 10; i++) mb[i] = 8'h00;
    k = 1;
    if (len > 0) begin
      mb[0] = {ic, ifn};
      if (len >= 2 && ic != 4'h7 && ic != 4'h8) begin
        mb[k] = {ra, rb};
        k++;
      end
      if (len >= 9) begin
        for (int b = 7; b >= 0; b--) begin
          mb[k] = vc[8*b +: 8];
          k++;
        end
      end
    end
  endtask

  task automatic model(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc);
    logic [63:0] room;
    build(ic, ifn, ra, rb, vc);
    if (mb_n == 0) begin
      exp_inv++;
    end else begin
      room = MEM_TOP - 64'(mb_n - 1);
      if (model_ptr > room) begin
        exp_ovf++;
      end else begin
        for (int i = 0; i < mb_n; i++) exp_q.push_back({model_ptr + 64'(i), mb[i]});
        model_ptr = model_ptr + 64'(mb_n);
      end
    end
  endtask

  // Present an instruction and return just after the accepting clock edge.
  task automatic present(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc);
    int n;
    @(negedge clk);
    iCode = ic; iFun = ifn; rA = ra; rB = rb; valC = vc; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready got 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    int n;
    model(ic, ifn, ra, rb, vc);
    present(ic, ifn, ra, rb, vc);
    @(negedge clk);
    // Scramble the fields: the encoder must be using its latched copy.
    in_valid = 1'b0;
    iCode = 4'($urandom); iFun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
    valC = {$urandom, $urandom};
    #1;
    n = 0;
    while (wr_en && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (wr_en) begin
      vectors++;
      miscompares++;
      $display("FAIL emit_timeout: wr_en got 1, expected 0");
    end
    @(negedge clk);
    #1;
    chk("wr_ptr", wr_ptr, model_ptr);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("inv_pulses", 64'(inv_cnt), 64'(exp_inv));
    chk("ovf_pulses", 64'(ovf_cnt), 64'(exp_ovf));
  endtask

  task automatic load(input logic [63:0] a);
    @(negedge clk);
    load_ptr = 1'b1;
    start_addr = a;
    #1;
    chk("ready_during_load", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    load_ptr = 1'b0;
    #1;
    chk("loaded_ptr", wr_ptr, a);
    model_ptr = a;
  endtask

  // Every write the DUT makes is checked against the model's queue.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (inv_err) inv_cnt++;
      if (ovf_err) ovf_cnt++;
      if (wr_en) begin
        log_a.push_back(wr_addr);
        log_d.push_back(wr_data);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.a || wr_data !== e.d) begin
            miscompares++;
            $display("FAIL write: got %0h:%0h, expected %0h:%0h", wr_addr, wr_data, e.a, e.d);
          end else begin
            $display("ok   write %0h:%02h", wr_addr, wr_data);
          end
        end
      end
    end
  end

  initial begin
    // Pin the model itself with hand-computed encodings.
    build(4'h3, 4'h0, 4'hF, 4'h3, 64'd2);
    chk("model_irmovq_len", 64'(mb_n), 64'd10);
    chk("model_irmovq_b0", 64'(mb[0]), 64'h30);
    chk("model_irmovq_b1", 64'(mb[1]), 64'hF3);
    chk("model_irmovq_b2", 64'(mb[2]), 64'h00);
    chk("model_irmovq_b9", 64'(mb[9]), 64'h02);
    build(4'h8, 4'h0, 4'h0, 4'h0, 64'h40);
    chk("model_call_len", 64'(mb_n), 64'd9);
    chk("model_call_b1", 64'(mb[1]), 64'h00);
    chk("model_call_b8", 64'(mb[8]), 64'h40);
    build(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
    chk("model_bad_len", 64'(mb_n), 64'd0);

    // Reset state.
    #2;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", wr_addr, 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_wr_ptr", wr_ptr, 64'd0);
    chk("rst_inv_err", 64'(inv_err), 64'd0);
    chk("rst_ovf_err", 64'(ovf_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // irmovq $2,%rbx at address 10.
    load(64'd10);
    base = log_a.size();
    send(4'h3, 4'h0, 4'hF, 4'h3, 64'd2);
    chk("irmovq_ptr", wr_ptr, 64'd20);
    chk("irmovq_first_addr", log_a[base], 64'd10);
    chk("irmovq_last", {log_a[base+9][55:0], log_d[base+9]}, {56'd19, 8'h02});

    // addq then call 0x40.
    base = log_a.size();
    send(4'h6, 4'h0, 4'h4, 4'h5, 64'hDEAD);
    send(4'h8, 4'h0, 4'hF, 4'hF, 64'h40);
    chk("addq_b0", {log_a[base][55:0], log_d[base]}, {56'd20, 8'h60});
    chk("addq_b1", {log_a[base+1][55:0], log_d[base+1]}, {56'd21, 8'h45});
    chk("call_b0", {log_a[base+2][55:0], log_d[base+2]}, {56'd22, 8'h80});
    chk("call_last", {log_a[base+10][55:0], log_d[base+10]}, {56'd30, 8'h40});
    chk("call_ptr", wr_ptr, 64'd31);

    // Illegal encodings.
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'd0);
    chk("bad_icode_ptr", wr_ptr, 64'd31);
    chk("bad_icode_inv", 64'(inv_cnt), 64'd1);
    send(4'h6, 4'h4, 4'h1, 4'h2, 64'd0);
    send(4'h7, 4'h7, 4'h0, 4'h0, 64'h100);

    // More legal forms: cmovge, pushq, jne.
    send(4'h2, 4'h5, 4'h1, 4'h2, 64'd0);
    send(4'hA, 4'h0, 4'h4, 4'hF, 64'd0);
    send(4'h7, 4'h4, 4'h0, 4'h0, 64'h1122334455667788);
    chk("jne_ptr", wr_ptr, 64'd44);

    // Memory-top boundary.
    load(64'd505);
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h10);
    chk("rmmovq_ovf", 64'(ovf_cnt), 64'd1);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    chk("nop_ptr", wr_ptr, 64'd506);
    load(64'd502);
    send(4'h3, 4'h0, 4'hF, 4'h7, 64'hA5A5);
    chk("exact_fit_ptr", wr_ptr, 64'd512);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    load(64'd511);
    send(4'h5, 4'h1, 4'h3, 4'h4, 64'd0);
    chk("inv_priority_ovf", 64'(ovf_cnt), 64'd2);
    load(64'hFFFF_FFFF_FFFF_FFFF);
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h40);
    chk("wrap_ovf", 64'(ovf_cnt), 64'd3);

    // Reset during the 4th byte of mrmovq.
    load(64'd100);
    base = log_a.size();
    model(4'h5, 4'h0, 4'h3, 4'h4, 64'h0102030405060708);
    present(4'h5, 4'h0, 4'h3, 4'h4, 64'h0102030405060708);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_wr_en", 64'(wr_en), 64'd0);
    chk("abort_wr_ptr", wr_ptr, 64'd0);
    chk("abort_bytes", 64'(log_a.size() - base), 64'd4);
    exp_q.delete();
    model_ptr = 64'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_abort", 64'(in_ready), 64'd1);

    // load_ptr together with in_valid: pointer loads, instruction is dropped.
    base = log_a.size();
    @(negedge clk);
    load_ptr = 1'b1; start_addr = 64'd300;
    iCode = 4'h1; iFun = 4'h0; in_valid = 1'b1;
    #1;
    chk("ready_load_valid", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    load_ptr = 1'b0;
    in_valid = 1'b0;
    model_ptr = 64'd300;
    repeat (3) @(negedge clk);
    #1;
    chk("load_valid_ptr", wr_ptr, 64'd300);
    chk("load_valid_writes", 64'(log_a.size() - base), 64'd0);

    // halt followed by nop.
    base = log_a.size();
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    chk("halt_write", {log_a[base][55:0], log_d[base]}, {56'd300, 8'h00});
`ifdef ENC_HALT_LOCK_EN
    @(negedge clk);
    iCode = 4'h1; iFun = 4'h0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("halt_lock_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    chk("halt_lock_writes", 64'(log_a.size() - base), 64'd1);
    load(64'd301);
`endif
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    chk("after_halt_nop", {log_a[log_a.size()-1][55:0], log_d[log_d.size()-1]}, {56'd301, 8'h10});
    chk("after_halt_ptr", wr_ptr, 64'd302);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y86_instr_encoder.md
Y86_INSTR_ENCODER -- requirements
Module: y86_instr_encoder

Interface
REQ-001 SHALL have parameter MEM_TOP, default 511, meaning the highest legal byte address of the instruction memory.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load_ptr  input  1  loads the write pointer from start_addr.
REQ-005 SHALL have port start_addr  input  64  the new write-pointer value.
REQ-006 SHALL have port in_valid  input  1  an instruction is presented.
REQ-007 SHALL have port in_ready  output  1  the encoder can accept an instruction.
REQ-008 SHALL have ports iCode, iFun, rA, rB  input  4 each  the instruction fields.
REQ-009 SHALL have port valC  input  64  the immediate, displacement or destination.
REQ-010 SHALL have ports wr_en  output  1, wr_addr  output  64, wr_data  output  8  the byte write to instruction memory.
REQ-011 SHALL have port wr_ptr  output  64  the current write pointer.
REQ-012 SHALL have ports inv_err  output  1 (invalid encoding) and ovf_err  output  1 (would exceed MEM_TOP), both one-cycle pulses.

Function
REQ-013 SHALL accept an instruction on a clock edge where in_valid, in_ready and !load_ptr are all high.
REQ-014 SHALL use these lengths: halt, nop and ret = 1; cmovXX (iFun<7), OPq (iFun<4), pushq and popq = 2; irmovq, rmmovq and mrmovq = 10; jXX (iFun<7) and call = 9.
REQ-015 SHALL use this byte order: byte0 = {iCode,iFun}; byte1 = {rA,rB} when length ≥ 2 and not jXX/call; valC follows MSB-first (irmovq/rmmovq/mrmovq in bytes 2..9, jXX/call in bytes 1..8).
REQ-016 SHALL implement FSM IDLE -> EMIT on a valid accept; EMIT -> IDLE after the last byte; in_ready=1 only in IDLE.
REQ-017 SHALL, in EMIT, assert wr_en for exactly one byte per cycle, with wr_addr = wr_ptr + byte index, starting the cycle after accept.
REQ-018 SHALL update wr_ptr to wr_ptr + length, modulo 2^64, on the cycle the last byte is written.
REQ-019 SHALL, for an invalid iCode/iFun at accept: write nothing, pulse inv_err the next cycle, leave wr_ptr unchanged, stay in IDLE.
REQ-020 SHALL, if wr_ptr + length − 1 > MEM_TOP (or the sum wraps) at accept: write nothing, pulse ovf_err, leave wr_ptr unchanged, stay in IDLE; inv_err takes priority over ovf_err.
REQ-021 SHALL, when load_ptr is asserted in IDLE, set wr_ptr = start_addr next cycle and force in_ready=0 that cycle; load_ptr SHALL be ignored in EMIT.
REQ-022 SHALL latch the instruction fields at accept, so input changes during EMIT have no effect.

Reset
REQ-023 SHALL, while rst is high, asynchronously force: state=IDLE, wr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, inv_err=0, ovf_err=0, in_ready=0.
REQ-024 SHALL, on reset mid-EMIT, abort the remaining bytes immediately and leave wr_ptr=0; in_ready SHALL rise the first cycle after rst deasserts.

Configuration
REQ-025 SHALL support macro ENC_HALT_LOCK_EN: when defined, once a halt byte is written, in_ready SHALL stay 0 until rst or load_ptr; when undefined, halt is treated like any 1-byte instruction.

Verification
REQ-026 SHALL cover: load_ptr with start_addr=10, then irmovq (3,0,rA=F,rB=3,valC=2) -> 10 writes at addr 10..19 with data 30,F3,00×7,02; wr_ptr=20.
REQ-027 SHALL cover: at wr_ptr=20, addq (6,0,rA=4,rB=5) then call (8,0,valC=0x40) -> writes 20:60, 21:45, then 22:80, 23..29:00, 30:40; wr_ptr=31.
REQ-028 SHALL cover: iCode=0xC presented -> no wr_en, one inv_err pulse, wr_ptr unchanged.
REQ-029 SHALL cover: wr_ptr=505, rmmovq presented -> ovf_err pulse, no writes; then nop -> single write at 505, wr_ptr=506.
REQ-030 SHALL cover: rst asserted on the 4th byte of mrmovq -> wr_en=0 immediately and wr_ptr=0; load_ptr together with in_valid -> pointer loaded, instruction not accepted.
REQ-031 SHALL cover, with ENC_HALT_LOCK_EN defined: halt then nop -> one write of 00, in_ready stays 0, nop not written until load_ptr.
